// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and
// flag bit positions inside the registered flag vector.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_W     = 4;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one bit of b per cycle, LSB first.
// done is high during the final iteration; product then carries that cycle's sum.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CW-1:0]      cnt;

  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    product = acc_nxt;
    done    = busy && (cnt == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete on the accepting edge; MUL iterates WIDTH cycles.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_ENABLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
  output state_t           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends on state only; out_valid holds until out_ready is seen.

  localparam int SW = $clog2(WIDTH);
  localparam bit USE_MUL = (MUL_ENABLE != 0);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   result_q;
  logic [FLAG_W-1:0]  flags_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   alu_res;
  logic [FLAG_W-1:0]  alu_flags;
  logic [FLAG_W-1:0]  mul_flags;

  logic               load_alu;
  logic               load_mul;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    shamt     = b[SW-1:0];
    alu_res   = '0;
    alu_flags = '0;
    case (alu_op)
      OP_ADD: begin
        alu_res               = sum[WIDTH-1:0];
        alu_flags[FLAG_CARRY] = sum[WIDTH];
        alu_flags[FLAG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // diff[WIDTH] is the borrow, so carry means a >= b unsigned
        alu_res               = diff[WIDTH-1:0];
        alu_flags[FLAG_CARRY] = ~diff[WIDTH];
        alu_flags[FLAG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_SLT: alu_res[0] = ($signed(a) < $signed(b));
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      default: alu_res = '0;
    endcase
    alu_flags[FLAG_ZERO] = (alu_res == '0);
    alu_flags[FLAG_NEG]  = alu_res[WIDTH-1];
  end

  always_comb begin
    mul_flags             = '0;
    mul_flags[FLAG_ZERO]  = (mul_prod[WIDTH-1:0] == '0);
    mul_flags[FLAG_NEG]   = mul_prod[WIDTH-1];
    mul_flags[FLAG_CARRY] = |mul_prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    mul_start = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (USE_MUL && (alu_op == OP_MUL)) begin
            mul_start = 1'b1;
            state_nxt = BUSY;
          end else begin
            load_alu  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          load_mul  = 1'b1;
          state_nxt = DONE;
        end else if (!mul_busy) begin
          // multiplier lost its job without finishing; recover to IDLE
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state <= state_nxt;
      if (load_alu) begin
        result_q <= alu_res;
        flags_q  <= alu_flags;
      end else if (load_mul) begin
        result_q <= mul_prod[WIDTH-1:0];
        flags_q  <= mul_flags;
      end
    end
  end

  assign result     = result_q;
  assign flag_zero  = flags_q[FLAG_ZERO];
  assign flag_neg   = flags_q[FLAG_NEG];
  assign flag_carry = flags_q[FLAG_CARRY];
  assign flag_ovf   = flags_q[FLAG_OVF];
  assign dbg_state  = state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus random ops checked against
// an arithmetic reference model through an expected-value queue.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_zero;
  logic         flag_neg;
  logic         flag_carry;
  logic         flag_ovf;
  state_t       dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_flags_q[$];

  alu_seq #(.WIDTH(W), .MUL_ENABLE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_op     (alu_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: flags packed as {ovf, carry, neg, zero}
  function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] x,
                                    input logic [W-1:0] y, output logic [W-1:0] r,
                                    output logic [3:0] f);
    longint unsigned t;
    logic c;
    logic o;
    c = 1'b0;
    o = 1'b0;
    t = 0;
    case (op)
      4'd0: begin
        t = longint'(x) + longint'(y);
        r = t[W-1:0];
        c = t[W];
        o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'd1: begin
        r = x - y;
        c = (x >= y);
        o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ~(x | y);
      4'd6: r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd7: r = x << (y % W);
      4'd8: r = x >> (y % W);
      4'd9: begin
        t = longint'(x) * longint'(y);
        r = t[W-1:0];
        c = ((t >> W) != 0);
      end
      default: r = '0;
    endcase
    f = {o, c, r[W-1], (r == 0)};
  endfunction

  // driver: issue one op, check latency, hold the result, then retire it
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int hold);
    logic [W-1:0] er;
    logic [3:0]   ef;
    int           lat;
    int           exp_lat;
    exp_lat = (op == 4'd9) ? W : 0;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    alu_op   = op;
    a        = x;
    b        = y;
    ref_model(op, x, y, er, ef);
    exp_q.push_back(er);
    exp_flags_q.push_back(ef);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alu_op   = 4'($urandom_range(0, 15));
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (!out_valid) begin
      check("out_valid_timeout", 64'(out_valid), 64'd1);
      void'(exp_q.pop_front());
      void'(exp_flags_q.pop_front());
      return;
    end
    er = exp_q.pop_front();
    ef = exp_flags_q.pop_front();
    check("result", 64'(result), 64'(er));
    check("flags", 64'({flag_ovf, flag_carry, flag_neg, flag_zero}), 64'(ef));
    if (hold > 0) begin
      in_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("held_valid", 64'(out_valid), 64'd1);
      check("held_result", 64'(result), 64'(er));
      check("held_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("retired_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    alu_op    = '0;
    rst_n     = 1'b0;

    // reset held with in_valid asserted: nothing may be captured
    in_valid = 1'b1;
    a        = 32'h1234_5678;
    b        = 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({flag_ovf, flag_carry, flag_neg, flag_zero}), 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // directed corner cases
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(OP_SUB, 32'd5, 32'd5, 0);
    run_op(OP_SUB, 32'd3, 32'd5, 0);
    run_op(OP_MUL, 32'h0001_0000, 32'h0001_0001, 5);
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(OP_SLT, 32'h1, 32'hFFFF_FFFF, 0);
    run_op(OP_SLL, 32'h1, 32'h25, 0);
    run_op(OP_SRL, 32'h8000_0000, 32'h20, 0);
    run_op(4'd12, 32'hDEAD_BEEF, 32'h1, 0);
    run_op(OP_NOR, 32'h0, 32'h0, 1);
    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // reset during a multiply: that op must never complete
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = OP_MUL;
    a        = 32'h3;
    b        = 32'h7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midmul_rst_valid", 64'(out_valid), 64'd0);
    check("midmul_rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midmul_no_output", 64'(seen), 64'd0);
    run_op(OP_ADD, 32'd2, 32'd3, 0);

    // random ops, small b values often to hit shift-by-0 and tiny shifts
    for (int i = 0; i < 60; i++) begin
      logic [3:0]   op;
      logic [W-1:0] x;
      logic [W-1:0] y;
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      if ($urandom_range(0, 7) == 0) y = x;
      run_op(op, x, y, $urandom_range(0, 2));
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
